cnt6_cycle_monitor: RTL and testbench

- Downstream consumer of the mod-6 counter (CNT6). Samples its binary count Q[2:0] and its decoded phase vector S[7:0] on every clock edge.
- Detects each completed 0..5 cycle (5->0 wrap) and counts completed cycles in a 2-digit BCD counter (00-99).
- Flags protocol errors: illegal count, S not matching Q, or an illegal step.
- Shares CLK/RST with CNT6 and feeds display/status logic.

---
 rtl/cnt6_cycle_monitor.sv | 171 +++++++++++++++++
 tb/tb_cnt6_cycle_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt6_cycle_monitor.sv
// ---------------------------------------------------------------------------
// cnt6_cycle_monitor
//
// Watches the outputs of a mod-6 counter (CNT6) and:
//   * detects each completed 0..5 cycle (a sampled 5->0 wrap),
//   * counts completed cycles in a two-digit BCD counter (00..99),
//   * flags protocol errors: count out of range, phase vector not matching
//     the count, or an illegal step between consecutive samples.
//
// Ports
//   CLK       in   1  system clock, rising-edge active
//   RST       in   1  synchronous active-high reset, overrides everything
//   Q         in   3  binary count from CNT6 (legal 0..5)
//   S         in   8  one-hot phase vector from CNT6 (legal S == 1 << Q)
//   EN        in   1  enable for the BCD cycle counter
//   CLR       in   1  synchronous clear of counts and sticky flags
//   WRAP      out  1  one-cycle pulse after a sampled 5->0 wrap
//   CYC_ONES  out  4  BCD ones digit of completed cycles
//   CYC_TENS  out  4  BCD tens digit of completed cycles
//   OVF       out  1  sticky, set when the count passes 99
//   ERR       out  1  sticky, set on any protocol error
//   PHASE_OK  out  1  registered, 1 = previous sample was error-free
//
// Parameters
//   HOLD_OK   1 = an unchanged count between samples is legal (stall)
//   SATURATE  1 = count holds at 99 on overflow, 0 = wraps to 00
// ---------------------------------------------------------------------------
module cnt6_cycle_monitor #(
  parameter bit HOLD_OK  = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] Q,
  input  logic [7:0] S,
  input  logic       EN,
  input  logic       CLR,
  output logic       WRAP,
  output logic [3:0] CYC_ONES,
  output logic [3:0] CYC_TENS,
  output logic       OVF,
  output logic       ERR,
  output logic       PHASE_OK
);

  localparam logic [2:0] Q_MAX = 3'd5;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Phase vector expected for a given count; out-of-range counts must come
  // with an all-zero vector.
  function automatic logic [7:0] expected_phase(input logic [2:0] q);
    logic [7:0] s;
    s = 8'h00;
    if (q <= Q_MAX) begin
      s = 8'h01 << q;
    end
    return s;
  endfunction

  // (q + 1) mod 6, defined for every 3-bit input so an out-of-range history
  // value still yields a well-defined successor.
  function automatic logic [2:0] succ_mod6(input logic [2:0] q);
    logic [2:0] n;
    case (q)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd4;
      3'd4:    n = 3'd5;
      3'd5:    n = 3'd0;
      3'd6:    n = 3'd1;
      default: n = 3'd2;
    endcase
    return n;
  endfunction

  // Registered state
  logic [2:0] q_hist_q, q_hist_d;
  logic       v_q, v_d;
  logic       wrap_q, wrap_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;
  logic       phase_ok_q, phase_ok_d;

  // Per-sample combinational checks
  logic wrap;
  logic e_range;
  logic e_dec;
  logic e_step;
  logic err;
  logic inc;

  always_comb begin
    wrap    = v_q && (q_hist_q == Q_MAX) && (Q == 3'd0);
    e_range = (Q > Q_MAX);
    e_dec   = (S != expected_phase(Q));
    // With no valid history (first sample after reset) the step is not judged.
    e_step  = v_q && !((Q == succ_mod6(q_hist_q)) ||
                       (HOLD_OK && (Q == q_hist_q)));
    err     = e_range | e_dec | e_step;
    inc     = wrap && EN && !CLR;
  end

  always_comb begin
    q_hist_d   = Q;
    v_d        = 1'b1;
    wrap_d     = wrap && !CLR;
    phase_ok_d = !err;
    err_d      = CLR ? 1'b0 : (err_q | err);
    ones_d     = ones_q;
    tens_d     = tens_q;
    ovf_d      = ovf_q;

    if (CLR) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
      ovf_d  = 1'b0;
    end else if (inc) begin
      if (ones_q >= BCD_MAX) begin
        if (tens_q >= BCD_MAX) begin
          // Passing 99: overflow is flagged whether we hold or roll over.
          ovf_d = 1'b1;
          if (SATURATE) begin
            ones_d = BCD_MAX;
            tens_d = BCD_MAX;
          end else begin
            ones_d = 4'd0;
            tens_d = 4'd0;
          end
        end else begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_hist_q   <= 3'd0;
      v_q        <= 1'b0;
      wrap_q     <= 1'b0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      phase_ok_q <= 1'b0;
    end else begin
      q_hist_q   <= q_hist_d;
      v_q        <= v_d;
      wrap_q     <= wrap_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      phase_ok_q <= phase_ok_d;
    end
  end

  assign WRAP     = wrap_q;
  assign CYC_ONES = ones_q;
  assign CYC_TENS = tens_q;
  assign OVF      = ovf_q;
  assign ERR      = err_q;
  assign PHASE_OK = phase_ok_q;

endmodule

// File: tb/tb_cnt6_cycle_monitor.sv
// Directed bench for cnt6_cycle_monitor. Two instances share stimulus:
//   u_a: HOLD_OK=1, SATURATE=0
//   u_b: HOLD_OK=0, SATURATE=1
module tb_cnt6_cycle_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] Q;
  logic [7:0] S;
  logic       EN;
  logic       CLR;

  logic       a_wrap, a_ovf, a_err, a_pok;
  logic [3:0] a_ones, a_tens;
  logic       b_wrap, b_ovf, b_err, b_pok;
  logic [3:0] b_ones, b_tens;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cnt6_cycle_monitor #(.HOLD_OK(1'b1), .SATURATE(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .Q(Q), .S(S), .EN(EN), .CLR(CLR),
    .WRAP(a_wrap), .CYC_ONES(a_ones), .CYC_TENS(a_tens),
    .OVF(a_ovf), .ERR(a_err), .PHASE_OK(a_pok)
  );

  cnt6_cycle_monitor #(.HOLD_OK(1'b0), .SATURATE(1'b1)) u_b (
    .CLK(CLK), .RST(RST), .Q(Q), .S(S), .EN(EN), .CLR(CLR),
    .WRAP(b_wrap), .CYC_ONES(b_ones), .CYC_TENS(b_tens),
    .OVF(b_ovf), .ERR(b_err), .PHASE_OK(b_pok)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply raw Q/S, clock once, settle past the edge.
  task automatic step_raw(input logic [2:0] q, input logic [7:0] s);
    Q = q;
    S = s;
    @(posedge CLK);
    #1;
  endtask

  // Apply a legal Q with its matching one-hot S.
  task automatic step(input logic [2:0] q);
    step_raw(q, 8'h01 << q);
  endtask

  // Check both instances report all-zero outputs.
  task automatic chk_zero(input string tag);
    chk({tag, "_a_wrap"}, {7'd0, a_wrap}, 8'd0);
    chk({tag, "_a_cnt"},  {a_tens, a_ones}, 8'h00);
    chk({tag, "_a_ovf"},  {7'd0, a_ovf}, 8'd0);
    chk({tag, "_a_err"},  {7'd0, a_err}, 8'd0);
    chk({tag, "_a_pok"},  {7'd0, a_pok}, 8'd0);
    chk({tag, "_b_wrap"}, {7'd0, b_wrap}, 8'd0);
    chk({tag, "_b_cnt"},  {b_tens, b_ones}, 8'h00);
    chk({tag, "_b_ovf"},  {7'd0, b_ovf}, 8'd0);
    chk({tag, "_b_err"},  {7'd0, b_err}, 8'd0);
    chk({tag, "_b_pok"},  {7'd0, b_pok}, 8'd0);
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; EN = 1'b1; Q = 3'd0; S = 8'h01;

    // Reset
    step(3'd0);
    chk_zero("rst");
    RST = 1'b0;

    // First full cycle 0..5,0
    step(3'd0);
    chk("first_pok", {7'd0, a_pok}, 8'd1);
    for (int i = 1; i <= 5; i++) begin
      step(3'(i));
      chk("nowrap_a", {7'd0, a_wrap}, 8'd0);
      chk("pok_a", {7'd0, a_pok}, 8'd1);
    end
    step(3'd0);
    chk("wrap1_a", {7'd0, a_wrap}, 8'd1);
    chk("wrap1_b", {7'd0, b_wrap}, 8'd1);
    chk("cnt1_a", {a_tens, a_ones}, 8'h01);
    step(3'd1);
    chk("wrap1_end_a", {7'd0, a_wrap}, 8'd0);
    chk("cnt1_hold_a", {a_tens, a_ones}, 8'h01);
    chk("err1_a", {7'd0, a_err}, 8'd0);
    chk("err1_b", {7'd0, b_err}, 8'd0);
    chk("pok1_b", {7'd0, b_pok}, 8'd1);

    // 98 more cycles -> 99
    for (int n = 0; n < 98; n++) begin
      step(3'd2); step(3'd3); step(3'd4); step(3'd5); step(3'd0); step(3'd1);
    end
    chk("cnt99_a", {a_tens, a_ones}, 8'h99);
    chk("cnt99_b", {b_tens, b_ones}, 8'h99);
    chk("ovf99_a", {7'd0, a_ovf}, 8'd0);
    chk("cnt50_mid_err_a", {7'd0, a_err}, 8'd0);

    // One more cycle -> overflow
    step(3'd2); step(3'd3); step(3'd4); step(3'd5); step(3'd0);
    chk("ovf_wrap_a", {a_tens, a_ones}, 8'h00);
    chk("ovf_flag_a", {7'd0, a_ovf}, 8'd1);
    chk("sat_b", {b_tens, b_ones}, 8'h99);
    chk("sat_flag_b", {7'd0, b_ovf}, 8'd1);
    step(3'd1);
    chk("ovf_sticky_a", {7'd0, a_ovf}, 8'd1);

    // Range error: Q=6, S=0
    step_raw(3'd6, 8'h00);
    chk("range_pok_a", {7'd0, a_pok}, 8'd0);
    chk("range_err_a", {7'd0, a_err}, 8'd1);
    chk("range_err_b", {7'd0, b_err}, 8'd1);
    step(3'd0);
    step(3'd1);
    chk("resume_pok_a", {7'd0, a_pok}, 8'd1);
    chk("resume_err_a", {7'd0, a_err}, 8'd1);

    // CLR clears counts and sticky flags
    CLR = 1'b1;
    step(3'd2);
    CLR = 1'b0;
    chk("clr_err_a", {7'd0, a_err}, 8'd0);
    chk("clr_cnt_a", {a_tens, a_ones}, 8'h00);
    chk("clr_ovf_a", {7'd0, a_ovf}, 8'd0);
    chk("clr_ovf_b", {7'd0, b_ovf}, 8'd0);
    chk("clr_pok_a", {7'd0, a_pok}, 8'd1);

    // Decode error: Q=3 with S=0x10
    step_raw(3'd3, 8'h10);
    chk("dec_pok_a", {7'd0, a_pok}, 8'd0);
    chk("dec_err_a", {7'd0, a_err}, 8'd1);
    CLR = 1'b1;
    step(3'd4);
    CLR = 1'b0;
    chk("dec_clr_err_a", {7'd0, a_err}, 8'd0);
    chk("dec_clr_pok_a", {7'd0, a_pok}, 8'd1);

    // Step error: 4 -> 0
    step(3'd0);
    chk("step_err_a", {7'd0, a_err}, 8'd1);
    chk("step_pok_a", {7'd0, a_pok}, 8'd0);
    chk("step_nowrap_a", {7'd0, a_wrap}, 8'd0);
    CLR = 1'b1;
    step(3'd1);
    CLR = 1'b0;

    // Hold at 2 for 3 cycles
    step(3'd2); step(3'd2); step(3'd2);
    chk("hold_err_a", {7'd0, a_err}, 8'd0);
    chk("hold_pok_a", {7'd0, a_pok}, 8'd1);
    chk("hold_err_b", {7'd0, b_err}, 8'd1);
    chk("hold_pok_b", {7'd0, b_pok}, 8'd0);
    CLR = 1'b1;
    step(3'd3);
    CLR = 1'b0;
    chk("hold_clr_b", {7'd0, b_err}, 8'd0);

    // Count to 0/7, then CLR coincident with a wrap
    step(3'd4); step(3'd5);
    for (int n = 0; n < 7; n++) begin
      step(3'd0); step(3'd1); step(3'd2); step(3'd3); step(3'd4); step(3'd5);
    end
    chk("cnt7_a", {a_tens, a_ones}, 8'h07);
    chk("cnt7_b", {b_tens, b_ones}, 8'h07);
    CLR = 1'b1;
    step(3'd0);
    CLR = 1'b0;
    chk("clrwrap_cnt_a", {a_tens, a_ones}, 8'h00);
    chk("clrwrap_wrap_a", {7'd0, a_wrap}, 8'd0);
    chk("clrwrap_ovf_a", {7'd0, a_ovf}, 8'd0);
    chk("clrwrap_err_a", {7'd0, a_err}, 8'd0);
    chk("clrwrap_err_b", {7'd0, b_err}, 8'd0);

    // EN=0 across two wraps
    EN = 1'b0;
    for (int n = 0; n < 2; n++) begin
      step(3'd1); step(3'd2); step(3'd3); step(3'd4); step(3'd5);
      chk("en0_prewrap_a", {7'd0, a_wrap}, 8'd0);
      step(3'd0);
      chk("en0_wrap_a", {7'd0, a_wrap}, 8'd1);
      chk("en0_cnt_a", {a_tens, a_ones}, 8'h00);
      chk("en0_cnt_b", {b_tens, b_ones}, 8'h00);
    end
    EN = 1'b1;
    chk("en0_err_a", {7'd0, a_err}, 8'd0);

    // Reset mid-cycle at Q=3, then restart at 0
    step(3'd1); step(3'd2); step(3'd3);
    chk("pre_rst_pok_a", {7'd0, a_pok}, 8'd1);
    RST = 1'b1;
    step(3'd3);
    chk_zero("midrst");
    RST = 1'b0;
    step(3'd0);
    chk("post_rst_err_a", {7'd0, a_err}, 8'd0);
    chk("post_rst_err_b", {7'd0, b_err}, 8'd0);
    chk("post_rst_wrap_a", {7'd0, a_wrap}, 8'd0);
    chk("post_rst_pok_a", {7'd0, a_pok}, 8'd1);
    chk("post_rst_pok_b", {7'd0, b_pok}, 8'd1);
    chk("post_rst_cnt_a", {a_tens, a_ones}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
